// File: rtl/sprite_blit_engine.sv
// rtl/sprite_blit_engine.sv - pitched sprite copy into the frame buffer with flips, colour key and screen clip
module sprite_blit_engine #(
    parameter int SrcAddrWidth = 16,
    parameter int CoordWidth   = 10,
    parameter int PixelWidth   = 16,
    parameter int SrcLatency   = 1,
    parameter int ScreenW      = 640,
    parameter int ScreenH      = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CoordWidth-1:0]   dest_x_start,
    input  logic [CoordWidth-1:0]   dest_x_end,
    input  logic [CoordWidth-1:0]   dest_y_start,
    input  logic [CoordWidth-1:0]   dest_y_end,
    input  logic [SrcAddrWidth-1:0] src_addr_start,
    input  logic [SrcAddrWidth-1:0] src_pitch,
    input  logic                    flip_x,
    input  logic                    flip_y,
    input  logic [PixelWidth-1:0]   key_color,
    input  logic                    key_en,
    input  logic                    execute,
    output logic                    busy,
    output logic                    done,
    output logic [SrcAddrWidth-1:0] src_addr,
    output logic                    src_rd,
    input  logic [PixelWidth-1:0]   src_data,
    output logic [CoordWidth-1:0]   program_x,
    output logic [CoordWidth-1:0]   program_y,
    output logic [PixelWidth-1:0]   program_data,
    output logic                    program_write
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CoordWidth:0] SCREEN_W = (CoordWidth+1)'(ScreenW);
    localparam logic [CoordWidth:0] SCREEN_H = (CoordWidth+1)'(ScreenH);

    state_t state, state_nxt;

    logic [CoordWidth-1:0]   x_start_q, x_end_q, y_start_q, y_end_q;
    logic [SrcAddrWidth-1:0] pitch_q, row_base;
    logic                    flip_x_q, flip_y_q, key_en_q;
    logic [PixelWidth-1:0]   key_q;
    logic [CoordWidth-1:0]   col, row;
    logic [2:0]              drain_cnt;

    logic [CoordWidth-1:0]   tag_x [SrcLatency];
    logic [CoordWidth-1:0]   tag_y [SrcLatency];
    logic                    tag_v [SrcLatency];

    logic [CoordWidth-1:0]   width, height, dx, dy;
    logic                    last_col, last_row, drain_last, degenerate, issue, abort;

    assign width      = x_end_q - x_start_q;
    assign height     = y_end_q - y_start_q;
    assign last_col   = (col == width - CoordWidth'(1));
    assign last_row   = (row == height - CoordWidth'(1));
    assign drain_last = (drain_cnt == 3'(SrcLatency - 1));
    assign degenerate = (dest_x_end <= dest_x_start) || (dest_y_end <= dest_y_start);
    assign issue      = (state == RUN) && execute;
    assign abort      = ((state == RUN) || (state == DRAIN)) && !execute;
    assign dx = flip_x_q ? (x_end_q - CoordWidth'(1) - col) : (x_start_q + col);
    assign dy = flip_y_q ? (y_end_q - CoordWidth'(1) - row) : (y_start_q + row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (execute) state_nxt = degenerate ? DONE : RUN;
            RUN:     if (!execute) state_nxt = IDLE;
                     else if (last_col && last_row) state_nxt = DRAIN;
            DRAIN:   if (!execute) state_nxt = IDLE;
                     else if (drain_last) state_nxt = DONE;
            DONE:    if (!execute) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
    end

    // Rows advance by adding the pitch to a running base, so no multiplier is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_start_q <= '0; x_end_q <= '0; y_start_q <= '0; y_end_q <= '0;
            pitch_q   <= '0; row_base <= '0; key_q <= '0;
            flip_x_q  <= 1'b0; flip_y_q <= 1'b0; key_en_q <= 1'b0;
            col       <= '0; row <= '0; drain_cnt <= '0;
            src_addr  <= '0; src_rd <= 1'b0;
        end else begin
            if (state == IDLE) begin
                x_start_q <= dest_x_start; x_end_q <= dest_x_end;
                y_start_q <= dest_y_start; y_end_q <= dest_y_end;
                pitch_q   <= src_pitch;    row_base <= src_addr_start;
                flip_x_q  <= flip_x;       flip_y_q <= flip_y;
                key_q     <= key_color;    key_en_q <= key_en;
                col       <= '0;           row      <= '0;
            end else if (issue) begin
                src_addr <= row_base + SrcAddrWidth'(col);
                if (last_col) begin
                    col      <= '0;
                    row      <= row + CoordWidth'(1);
                    row_base <= row_base + pitch_q;
                end else begin
                    col <= col + CoordWidth'(1);
                end
            end
            src_rd    <= issue;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Tag delay line: the tail lines up with src_data for the same read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SrcLatency; i++) begin
                tag_x[i] <= '0; tag_y[i] <= '0; tag_v[i] <= 1'b0;
            end
        end else if (abort) begin
            for (int i = 0; i < SrcLatency; i++) tag_v[i] <= 1'b0;
        end else begin
            tag_x[0] <= dx; tag_y[0] <= dy; tag_v[0] <= issue;
            for (int i = 1; i < SrcLatency; i++) begin
                tag_x[i] <= tag_x[i-1]; tag_y[i] <= tag_y[i-1]; tag_v[i] <= tag_v[i-1];
            end
        end
    end

    always_comb begin
        program_x     = tag_x[SrcLatency-1];
        program_y     = tag_y[SrcLatency-1];
        program_data  = src_data;
        program_write = tag_v[SrcLatency-1] && !(key_en_q && (src_data == key_q))
                        && ({1'b0, program_x} < SCREEN_W) && ({1'b0, program_y} < SCREEN_H);
    end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// tb/tb_sprite_blit_engine.sv - randomized bench for sprite_blit_engine at source latencies 1, 2 and 3
module tb_sprite_blit_engine;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  dxs, dxe, dys, dye;
    logic [15:0] sas, spitch, key;
    logic        fx, fy, ken, execute;

    logic        busy_o [NI], done_o [NI], rd_o [NI], pw_o [NI];
    logic [15:0] sa_o [NI], sd [NI], pd_o [NI], ad1 [NI], ad2 [NI];
    logic [9:0]  px_o [NI], py_o [NI];
    logic [15:0] mem [0:65535];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, job_id = 0, seen_job = 0;
    int wn [NI], rn [NI], bn [NI], done_cyc [NI];
    logic [63:0] wlog [NI][64];
    logic [15:0] rlog [NI][64];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sprite_blit_engine #(.SrcLatency(g + 1)) u_dut (
            .clk(clk), .reset(rst),
            .dest_x_start(dxs), .dest_x_end(dxe), .dest_y_start(dys), .dest_y_end(dye),
            .src_addr_start(sas), .src_pitch(spitch), .flip_x(fx), .flip_y(fy),
            .key_color(key), .key_en(ken), .execute(execute),
            .busy(busy_o[g]), .done(done_o[g]), .src_addr(sa_o[g]), .src_rd(rd_o[g]),
            .src_data(sd[g]), .program_x(px_o[g]), .program_y(py_o[g]),
            .program_data(pd_o[g]), .program_write(pw_o[g])
        );
    end

    always #10 clk = ~clk;

    // Source memory: data appears SrcLatency cycles after the issuing cycle.
    assign sd[0] = mem[sa_o[0]];
    assign sd[1] = mem[ad1[1]];
    assign sd[2] = mem[ad2[2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            ad1[i] <= sa_o[i];
            ad2[i] <= ad1[i];
        end
    end

    always @(negedge clk) begin
        if (seen_job != job_id) begin
            seen_job = job_id;
            for (int i = 0; i < NI; i++) begin
                wn[i] = 0; rn[i] = 0; bn[i] = 0; done_cyc[i] = -1;
            end
        end
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (pw_o[i]) begin
                    if (wn[i] < 64) wlog[i][wn[i]] = {12'd0, 16'(cyc), px_o[i], py_o[i], pd_o[i]};
                    wn[i]++;
                end
                if (rd_o[i]) begin
                    if (rn[i] < 64) rlog[i][rn[i]] = sa_o[i];
                    rn[i]++;
                end
                if (busy_o[i]) bn[i]++;
                if (done_o[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++)
            check($sformatf("%s_L%0d", tag, i + 1),
                  {busy_o[i], done_o[i], rd_o[i], pw_o[i], sa_o[i], px_o[i], py_o[i]}, 64'd0);
    endtask

    task automatic run_job(input int x0, input int x1, input int y0, input int y1,
                           input int st, input int pt, input bit f_x, input bit f_y,
                           input int k, input bit k_en, input int abort_after);
        int w, h, n, c0, ab, t, lim, er, ewn, lat;
        logic [15:0] a;
        logic [15:0] qa[$], qd[$];
        int qx[$], qy[$];
        bit qwe[$];
        @(negedge clk);
        execute = 1'b0;
        dxs = 10'(x0); dxe = 10'(x1); dys = 10'(y0); dye = 10'(y1);
        sas = 16'(st); spitch = 16'(pt); fx = f_x; fy = f_y; key = 16'(k); ken = k_en;
        job_id++;
        @(negedge clk);
        execute = 1'b1;
        c0 = cyc;
        w = (x1 > x0) ? x1 - x0 : 0;
        h = (y1 > y0) ? y1 - y0 : 0;
        n = w * h;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                int xx, yy;
                a  = 16'(st + r * pt + c);
                xx = f_x ? x1 - 1 - c : x0 + c;
                yy = f_y ? y1 - 1 - r : y0 + r;
                qa.push_back(a); qd.push_back(mem[a]); qx.push_back(xx); qy.push_back(yy);
                qwe.push_back(xx < 640 && yy < 480 && !(k_en && mem[a] == 16'(k)));
            end
        ab = -1;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (abort_after > 0) begin
                if (ab < 0 && cyc == c0 + abort_after + 1) begin
                    execute = 1'b0;
                    ab = cyc;
                end else if (ab >= 0 && cyc == ab + 1) begin
                    for (int i = 0; i < NI; i++)
                        check($sformatf("abort_idle_L%0d", i + 1), {busy_o[i], rd_o[i]}, 64'd0);
                end
                if (ab >= 0 && cyc >= ab + 6) break;
            end else if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && done_cyc[2] >= 0) begin
                break;
            end
        end
        check("bounded_wait", 64'(t < 500), 64'd1);
        if (abort_after == 0) begin
            repeat (2) @(negedge clk);
            execute = 1'b0;
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                check($sformatf("done_release_L%0d", i + 1), 64'(done_o[i]), 64'd0);
        end
        for (int i = 0; i < NI; i++) begin
            lat = i + 1;
            er  = (abort_after > 0 && abort_after < n) ? abort_after : n;
            lim = (abort_after > 0) ? abort_after + 1 - lat : n;
            if (lim > n) lim = n;
            check($sformatf("rd_count_L%0d", lat), 64'(rn[i]), 64'(er));
            for (int j = 0; j < er && j < 64; j++)
                check($sformatf("rd_addr_L%0d_%0d", lat, j), 64'(rlog[i][j]), 64'(qa[j]));
            ewn = 0;
            for (int j = 0; j < lim; j++)
                if (qwe[j]) begin
                    if (ewn < 64)
                        check($sformatf("write_L%0d_%0d", lat, ewn), wlog[i][ewn],
                              {12'd0, 16'(c0 + 1 + lat + j), 10'(qx[j]), 10'(qy[j]), qd[j]});
                    ewn++;
                end
            check($sformatf("wr_count_L%0d", lat), 64'(wn[i]), 64'(ewn));
            if (abort_after == 0) begin
                check($sformatf("done_latency_L%0d", lat), 64'(done_cyc[i] - c0),
                      64'((n == 0) ? 1 : n + lat + 1));
                check($sformatf("busy_cycles_L%0d", lat), 64'(bn[i]), 64'((n == 0) ? 0 : n + lat));
            end else begin
                check($sformatf("no_done_L%0d", lat), 64'(done_cyc[i] < 0), 64'd1);
            end
        end
    endtask

    initial begin
        logic [15:0] pal [4];
        int x0, y0, w, h;
        pal[0] = 16'h07E0; pal[1] = 16'hF800; pal[2] = 16'h001F; pal[3] = 16'hFFFF;
        for (int i = 0; i < 65536; i++) mem[i] = pal[$urandom_range(0, 3)];
        for (int i = 0; i < 8; i++) mem[16'h100 + i] = 16'h1000 + 16'(i);
        mem[16'h102] = 16'h07E0;
        dxs = '0; dxe = '0; dys = '0; dye = '0; sas = '0; spitch = '0;
        fx = 1'b0; fy = 1'b0; key = '0; ken = 1'b0; execute = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        run_job(10, 14, 20, 22, 16'h100, 4, 0, 0, 16'h07E0, 0, 0);
        check("plain_first", wlog[0][0][35:0], {10'd10, 10'd20, 16'h1000});
        check("plain_done10", 64'(done_cyc[0] - done_cyc[0] + 10), 64'(8 + 1 + 1));
        run_job(10, 14, 20, 22, 16'h100, 4, 1, 1, 16'h07E0, 0, 0);
        check("flip_first", wlog[0][0][35:0], {10'd13, 10'd21, 16'h1000});
        check("flip_last", wlog[0][7][35:0], {10'd10, 10'd20, 16'h1007});
        run_job(10, 14, 20, 22, 16'h100, 4, 0, 0, 16'h07E0, 1, 0);
        check("key_skips", 64'(wn[0]), 64'd7);
        run_job(10, 14, 20, 22, 16'h100, 4, 0, 0, 16'h07E0, 0, 0);
        check("key_off_writes", 64'(wn[0]), 64'd8);
        run_job(636, 642, 100, 102, 16'h2000, 6, 0, 0, 0, 0, 0);
        check("clip_writes_L3", 64'(wn[2]), 64'd8);
        run_job(10, 20, 30, 33, 16'h3000, 40, 0, 0, 0, 0, 5);
        run_job(50, 50, 10, 20, 16'h4000, 8, 0, 0, 0, 0, 0);
        run_job(50, 60, 10, 10, 16'h4000, 8, 0, 0, 0, 0, 0);

        for (int j = 0; j < 10; j++) begin
            w  = $urandom_range(1, 8);
            h  = $urandom_range(1, 4);
            x0 = ($urandom_range(0, 1) != 0) ? $urandom_range(630, 645) : $urandom_range(0, 600);
            y0 = ($urandom_range(0, 1) != 0) ? $urandom_range(474, 480) : $urandom_range(0, 400);
            run_job(x0, x0 + w, y0, y0 + h, $urandom_range(0, 65535), $urandom_range(0, 300),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    pal[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 0);
        end

        @(negedge clk);
        dxs = 10'd0; dxe = 10'd20; dys = 10'd0; dye = 10'd4; sas = 16'h500; spitch = 16'd20;
        fx = 1'b0; fy = 1'b0; ken = 1'b0;
        execute = 1'b1;
        repeat (6) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_reset");
        execute = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("post_reset_idle_L%0d", i + 1), {busy_o[i], done_o[i], pw_o[i]}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
